seg7_capture: RTL and testbench

- Receiving end of the multiplexed 7-segment display interface: snoops the active-low segment bus and the one-hot digit-enable bus, and recovers the hex nibble shown on each digit.
- A pattern is accepted only after it has been stable for a programmable number of clocks.
- Used for loopback self-test of the display path and for board-level capture of display state.

---
 rtl/seg7_capture.sv | 175 +++++++++++++++++
 tb/tb_seg7_capture.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// Multiplexed 7-segment bus snooper: recovers the hex nibble on each digit once a pattern is stable.
// Optional macro SEG7_CAPTURE_BLANK_EN makes the all-off pattern a legal blank that invalidates the digit.
module seg7_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [6:0]              seg_i,
  input  logic [NUM_DIGITS-1:0]   dig_i,
  input  logic                    clr_i,
  output logic [4*NUM_DIGITS-1:0] hex_o,
  output logic [NUM_DIGITS-1:0]   valid_o,
  output logic [NUM_DIGITS-1:0]   err_o,
  output logic                    upd_o
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [6:0]              cap_seg_q, cap_seg_d;
  logic [NUM_DIGITS-1:0]   cap_dig_q, cap_dig_d;
  logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    upd_q, upd_d;

  logic                    sel_ok, same, commit;
  logic [CW-1:0]           cnt_inc;
  logic [5:0]              dec;

  // Returns {blank, legal, nibble}.
  function automatic logic [5:0] decode(input logic [6:0] seg);
    logic [5:0] r;
    case (seg)
      7'b1000000: r = {2'b01, 4'h0};
      7'b1111001: r = {2'b01, 4'h1};
      7'b0100100: r = {2'b01, 4'h2};
      7'b0110000: r = {2'b01, 4'h3};
      7'b0011001: r = {2'b01, 4'h4};
      7'b0010010: r = {2'b01, 4'h5};
      7'b0000010: r = {2'b01, 4'h6};
      7'b1111000: r = {2'b01, 4'h7};
      7'b0000000: r = {2'b01, 4'h8};
      7'b0010000: r = {2'b01, 4'h9};
      7'b0001000: r = {2'b01, 4'hA};
      7'b0000011: r = {2'b01, 4'hB};
      7'b1000110: r = {2'b01, 4'hC};
      7'b0100001: r = {2'b01, 4'hD};
      7'b0000110: r = {2'b01, 4'hE};
      7'b0001110: r = {2'b01, 4'hF};
`ifdef SEG7_CAPTURE_BLANK_EN
      7'b1111111: r = {2'b10, 4'h0};
`endif
      default:    r = 6'b000000;
    endcase
    return r;
  endfunction

  always_comb begin
    sel_ok    = (dig_i != '0) && ((dig_i & (dig_i - 1'b1)) == '0);
    same      = (seg_i == cap_seg_q) && (dig_i == cap_dig_q);
    cnt_inc   = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    dec       = decode(seg_i);
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_seg_d = cap_seg_q;
    cap_dig_d = cap_dig_q;
    commit    = 1'b0;

    case (state_q)
      IDLE: begin
        if (sel_ok) begin
          cap_seg_d = seg_i;
          cap_dig_d = dig_i;
          cnt_d     = CNT_ONE;
          state_d   = TRACK;
        end
      end
      TRACK: begin
        if (same) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            commit  = 1'b1;
            state_d = HOLD;
          end
        end else if (sel_ok) begin
          cap_seg_d = seg_i;
          cap_dig_d = dig_i;
          cnt_d     = CNT_ONE;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (!same) begin
          if (sel_ok) begin
            cap_seg_d = seg_i;
            cap_dig_d = dig_i;
            cnt_d     = CNT_ONE;
            state_d   = TRACK;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // A single stable sample is enough: any fresh capture commits immediately.
    if (STABLE_CYCLES == 1 && sel_ok && state_d == TRACK) begin
      commit  = 1'b1;
      state_d = HOLD;
    end

    hex_d   = hex_q;
    valid_d = clr_i ? '0 : valid_q;
    err_d   = clr_i ? '0 : err_q;
    upd_d   = commit;
    if (commit) begin
      for (int n = 0; n < NUM_DIGITS; n++) begin
        if (dig_i[n]) begin
          if (dec[5]) begin
            valid_d[n] = 1'b0;
            err_d[n]   = 1'b0;
          end else if (dec[4]) begin
            hex_d[4*n +: 4] = dec[3:0];
            valid_d[n]      = 1'b1;
            err_d[n]        = 1'b0;
          end else begin
            err_d[n] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cap_seg_q <= '0;
      cap_dig_q <= '0;
      hex_q     <= '0;
      valid_q   <= '0;
      err_q     <= '0;
      upd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cap_seg_q <= cap_seg_d;
      cap_dig_q <= cap_dig_d;
      hex_q     <= hex_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      upd_q     <= upd_d;
    end
  end

  assign hex_o   = hex_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;
  assign upd_o   = upd_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture (defaults NUM_DIGITS=4, STABLE_CYCLES=4).
// Expected commit results are queued by the stimulus; the monitor pops one per upd_o cycle.
module tb_seg7_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  dig;
  logic        clr;
  logic [15:0] hex;
  logic [3:0]  valid;
  logic [3:0]  err;
  logic        upd;

  int checks = 0;
  int errors = 0;
  logic [23:0] expq[$];

  seg7_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .seg_i(seg), .dig_i(dig), .clr_i(clr),
    .hex_o(hex), .valid_o(valid), .err_o(err), .upd_o(upd)
  );

  always #5 clk = ~clk;

  // Monitor: every upd_o cycle must match the next queued {hex, valid, err}.
  always @(negedge clk) begin
    if (rst_n && upd) begin
      logic [23:0] e;
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL spurious_upd actual hex=%h valid=%b err=%b required no update", hex, valid, err);
      end else begin
        e = expq.pop_front();
        if ({hex, valid, err} !== e) begin
          errors++;
          $display("FAIL commit actual hex=%h valid=%b err=%b required hex=%h valid=%b err=%b",
                   hex, valid, err, e[23:8], e[7:4], e[3:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] s, input logic [3:0] d, input int n);
    seg = s;
    dig = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] h, input logic [3:0] v, input logic [3:0] e);
    expq.push_back({h, v, e});
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; seg = '0; dig = '0;
    repeat (3) begin
      seg = 7'($urandom);
      dig = 4'($urandom);
      @(posedge clk);
      #1;
    end
    chk("rst_hex", 32'(hex), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_upd", 32'(upd), 32'h0);
    rst_n = 1'b1;
    drive(7'b1000000, 4'b0000, 2);

    // Basic capture of "2" on digit 0, then a long hold.
    push(16'h0002, 4'b0001, 4'b0000);
    drive(7'b0100100, 4'b0001, 3);
    chk("basic_not_yet", 32'(valid), 32'h0);
    drive(7'b0100100, 4'b0001, 11);
    drive(7'b0000000, 4'b0000, 2);

    // Glitch reject: 4 for three edges, then 5 for four edges.
    push(16'h0052, 4'b0011, 4'b0000);
    drive(7'b0011001, 4'b0010, 3);
    drive(7'b0010010, 4'b0010, 4);
    drive(7'b0000000, 4'b0000, 2);

    // Illegal pattern on digit 2, then a non-one-hot select that never commits.
    push(16'h0052, 4'b0011, 4'b0100);
    drive(7'b1110111, 4'b0100, 4);
    drive(7'b0000000, 4'b0000, 2);
    drive(7'b1000000, 4'b0110, 8);

    // Full scan A,B,C,D on digits 0..3.
    push(16'h005A, 4'b0011, 4'b0100);
    push(16'h00BA, 4'b0011, 4'b0100);
    push(16'h0CBA, 4'b0111, 4'b0000);
    push(16'hDCBA, 4'b1111, 4'b0000);
    drive(7'b0001000, 4'b0001, 4);
    drive(7'b0000011, 4'b0010, 4);
    drive(7'b1000110, 4'b0100, 4);
    drive(7'b0100001, 4'b1000, 4);

    // clr_i on the commit edge of digit 1.
    push(16'hDC1A, 4'b0010, 4'b0000);
    drive(7'b1111001, 4'b0010, 3);
    clr = 1'b1;
    drive(7'b1111001, 4'b0010, 1);
    clr = 1'b0;
    drive(7'b1111001, 4'b0010, 2);

    // Commit 8 on digit 0, then the all-off pattern.
    push(16'hDC18, 4'b0011, 4'b0000);
    drive(7'b0000000, 4'b0001, 4);
`ifdef SEG7_CAPTURE_BLANK_EN
    push(16'hDC18, 4'b0010, 4'b0000);
`else
    push(16'hDC18, 4'b0011, 4'b0001);
`endif
    drive(7'b1111111, 4'b0001, 4);
    drive(7'b1111111, 4'b0001, 3);

    // Plain clear with no commit.
    clr = 1'b1;
    drive(7'b0000000, 4'b0000, 1);
    clr = 1'b0;
    chk("clr_valid", 32'(valid), 32'h0);
    chk("clr_hex", 32'(hex), 32'hDC18);

    // Reset in the middle of tracking discards the partial count.
    drive(7'b0000000, 4'b0100, 2);
    rst_n = 1'b0;
    drive(7'b0000000, 4'b0100, 1);
    chk("midrst_hex", 32'(hex), 32'h0);
    chk("midrst_valid", 32'(valid), 32'h0);
    rst_n = 1'b1;
    push(16'h0800, 4'b0100, 4'b0000);
    drive(7'b0000000, 4'b0100, 3);
    chk("midrst_restart", 32'(valid), 32'h0);
    drive(7'b0000000, 4'b0100, 1);
    drive(7'b0000000, 4'b0000, 3);

    chk("queue_drained", 32'(expq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
